// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execution stage fed by the register-file ALU and S-bus read
// ports. Runs one operation per accepted start (single-cycle logic/arithmetic
// or a 32-step shift-add multiply) and returns the result to the S-bus write
// port with a one-cycle write-select strobe.
module alu_exec_unit #(
   parameter int WIDTH = 32,
   parameter int SEL_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [SEL_W-1:0] dest,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic [SEL_W-1:0] wr_sel,
   output logic [WIDTH-1:0] wb_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MUL  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   // The multiply always runs 32 steps; the counter value on the final step.
   localparam logic [4:0] LAST_STEP = 5'd31;

   state_t             state;
   logic [2:0]         op_q;
   logic [SEL_W-1:0]   dest_q;
   // opa_q doubles as the shifting multiplicand, opb_q as the shifting multiplier.
   logic [WIDTH-1:0]   opa_q;
   logic [WIDTH-1:0]   opb_q;
   logic [WIDTH-1:0]   prod;
   logic [4:0]         step_cnt;

   logic [WIDTH:0]     add_ext;
   logic [WIDTH-1:0]   exec_result;
   logic               exec_carry;
   logic [WIDTH-1:0]   mul_sum;

   // Single-cycle operation result computed from the captured operands.
   always_comb begin
      exec_result = '0;
      exec_carry  = 1'b0;
      add_ext     = {1'b0, opa_q} + {1'b0, opb_q};
      case (op_q)
         OP_ADD: begin
            exec_result = add_ext[WIDTH-1:0];
            exec_carry  = add_ext[WIDTH];
         end
         OP_SUB: begin
            exec_result = opa_q - opb_q;
            exec_carry  = (opa_q < opb_q);
         end
         OP_AND: exec_result = opa_q & opb_q;
         OP_OR:  exec_result = opa_q | opb_q;
         OP_XOR: exec_result = opa_q ^ opb_q;
         OP_SLL: exec_result = opa_q << opb_q[4:0];
         OP_SRL: exec_result = opa_q >> opb_q[4:0];
         default: begin
            exec_result = '0;
            exec_carry  = 1'b0;
         end
      endcase
   end

   // Partial product after the current shift-add step.
   always_comb begin
      mul_sum = prod;
      if (opb_q[0]) begin
         mul_sum = prod + opa_q;
      end
   end

   // Control FSM with registered result, flags and writeback strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         op_q     <= OP_ADD;
         dest_q   <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         prod     <= '0;
         step_cnt <= '0;
         result   <= '0;
         carry    <= 1'b0;
         done     <= 1'b0;
         wr_sel   <= '0;
      end else begin
         done   <= 1'b0;
         wr_sel <= '0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q     <= op;
                  dest_q   <= dest;
                  opa_q    <= a;
                  opb_q    <= b;
                  prod     <= '0;
                  step_cnt <= '0;
                  state    <= (op == OP_MUL) ? MUL : EXEC;
               end
            end
            EXEC: begin
               result <= exec_result;
               carry  <= exec_carry;
               done   <= 1'b1;
               wr_sel <= dest_q;
               state  <= DONE;
            end
            MUL: begin
               prod     <= mul_sum;
               opa_q    <= opa_q << 1;
               opb_q    <= opb_q >> 1;
               step_cnt <= step_cnt + 5'd1;
               if (step_cnt == LAST_STEP) begin
                  result <= mul_sum;
                  carry  <= 1'b0;
                  done   <= 1'b1;
                  wr_sel <= dest_q;
                  state  <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy    = (state != IDLE);
   assign zero    = (result == '0);
   assign wb_data = result;

endmodule
